// File: rtl/ram_cmd_ctrl.sv
// rtl/ram_cmd_ctrl.sv - command sequencer driving a single-port RAM (write, fill, dump)
module ram_cmd_ctrl #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FILL,
        S_DUMP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_nxt;
    logic              done_q;
    logic              done_nxt;

    logic              last_cnt;
    logic [ADDR_W-1:0] cnt_addr;

    // One extra counter bit lets the terminal compare stop the sweep cleanly.
    assign last_cnt = (cnt == LAST_CNT);
    assign cnt_addr = cnt[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_nxt = cmd_addr;
                    data_nxt = cmd_data;
                    cnt_nxt  = '0;
                    case (cmd_op)
                        OP_WRITE: state_nxt = S_WRITE;
                        OP_FILL:  state_nxt = S_FILL;
                        OP_DUMP:  state_nxt = S_DUMP;
                        default:  state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WRITE: begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
            S_FILL: begin
                if (last_cnt) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_DUMP: begin
                // Hold the beat until the downstream takes it.
                if (out_ready) begin
                    if (last_cnt) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        out_valid   = 1'b0;
        out_addr    = '0;
        out_data    = '0;
        ram_addr    = '0;
        ram_wr_en   = 1'b0;
        ram_wr_data = '0;

        case (state)
            S_IDLE: cmd_ready = 1'b1;
            S_WRITE: begin
                ram_wr_en   = 1'b1;
                ram_addr    = addr_q;
                ram_wr_data = data_q;
            end
            S_FILL: begin
                ram_wr_en   = 1'b1;
                ram_addr    = cnt_addr;
                ram_wr_data = data_q + DATA_W'(cnt_addr);
            end
            S_DUMP: begin
                out_valid = 1'b1;
                ram_addr  = cnt_addr;
                out_addr  = cnt_addr;
                out_data  = ram_rd_data;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// tb/tb_ram_cmd_ctrl.sv - directed bench with transaction-level model for ram_cmd_ctrl
module tb_ram_cmd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_addr;
    logic [7:0] out_data;
    logic [1:0] ram_addr;
    logic       ram_wr_en;
    logic [7:0] ram_wr_data;
    logic [7:0] ram_rd_data;
    logic       done;

    int checks = 0;
    int errors = 0;

    ram_cmd_ctrl #(.ADDR_W(2), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM behind the controller: combinational read, synchronous write.
    logic [7:0] ram_mem [4];
    always @(posedge clk) if (ram_wr_en) ram_mem[ram_addr] <= ram_wr_data;
    assign ram_rd_data = ram_mem[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending RAM actions of the current op, one per cycle (writes) or per handshake (reads).
    typedef struct {
        bit         is_rd;
        logic [1:0] a;
        logic [7:0] d;
    } act_t;
    act_t       q[$];
    logic [7:0] mem_m [4];
    bit         done_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            done_m = 1'b0;
        end else begin
            bit took;
            took   = 1'b0;
            done_m = 1'b0;
            if (q.size() == 0) begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b00: q.push_back('{1'b0, cmd_addr, cmd_data});
                        2'b01: for (int i = 0; i < 4; i++) q.push_back('{1'b0, 2'(i), 8'(cmd_data + 8'(i))});
                        2'b10: for (int i = 0; i < 4; i++) q.push_back('{1'b1, 2'(i), mem_m[i]});
                        default: ;
                    endcase
                end
            end else if (!q[0].is_rd) begin
                mem_m[q[0].a] = q[0].d;
                void'(q.pop_front());
                took = 1'b1;
            end else if (out_ready) begin
                void'(q.pop_front());
                took = 1'b1;
            end
            if (took && q.size() == 0) done_m = 1'b1;
        end
    end

    always @(negedge clk) begin
        bit busy;
        busy = (q.size() != 0);
        chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(busy && !q[0].is_rd));
        chk("out_valid", 32'(out_valid), 32'(busy && q[0].is_rd));
        chk("done", 32'(done), 32'(done_m));
        if (busy && !q[0].is_rd) begin
            chk("ram_addr_wr", 32'(ram_addr), 32'(q[0].a));
            chk("ram_wr_data", 32'(ram_wr_data), 32'(q[0].d));
        end else if (busy) begin
            chk("ram_addr_rd", 32'(ram_addr), 32'(q[0].a));
            chk("out_addr", 32'(out_addr), 32'(q[0].a));
            chk("out_data", 32'(out_data), 32'(q[0].d));
        end else begin
            chk("idle_ram_addr", 32'(ram_addr), 32'd0);
            chk("idle_wr_data", 32'(ram_wr_data), 32'd0);
            chk("idle_out_addr", 32'(out_addr), 32'd0);
        end
    end

    // Activity logs used by the literal checks.
    typedef struct packed {
        logic [1:0] a;
        logic [7:0] d;
    } pair_t;
    pair_t wr_log[$];
    pair_t rd_log[$];
    int    done_cnt;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wr_en) wr_log.push_back({ram_addr, ram_wr_data});
            if (out_valid && out_ready) rd_log.push_back({out_addr, out_data});
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        done_cnt = 0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d);
        int n;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int busy_cycles);
        busy_cycles = 0;
        while (!cmd_ready && busy_cycles < 50) begin tick(); busy_cycles++; end
        if (busy_cycles >= 50) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_four(input string nm, input bit use_rd,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
        pair_t lg[$];
        logic [7:0] e [4];
        e[0] = d0; e[1] = d1; e[2] = d2; e[3] = d3;
        lg = use_rd ? rd_log : wr_log;
        chk({nm, "_count"}, 32'(lg.size()), 32'd4);
        if (lg.size() == 4)
            for (int i = 0; i < 4; i++) chk({nm, "_entry"}, 32'(lg[i]), 32'({2'(i), e[i]}));
    endtask

    initial begin
        int bc;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        out_ready = 1'b1; done_cnt = 0;
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Single write
        clear_logs();
        send_cmd(2'b00, 2'd2, 8'hA5);
        wait_idle(bc);
        chk("wr_busy_cycles", 32'(bc), 32'd1);
        chk("wr_done_now", 32'(done), 32'd1);
        tick();
        chk("wr_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() == 1) chk("wr_entry", 32'(wr_log[0]), 32'({2'd2, 8'hA5}));
        chk("wr_done_cnt", 32'(done_cnt), 32'd1);

        // Fill with wraparound of the seed
        clear_logs();
        send_cmd(2'b01, 2'd0, 8'hFE);
        wait_idle(bc);
        chk("fill_busy_cycles", 32'(bc), 32'd4);
        tick();
        check_four("fill", 1'b0, 8'hFE, 8'hFF, 8'h00, 8'h01);
        chk("fill_done_cnt", 32'(done_cnt), 32'd1);

        // Streaming dump
        clear_logs();
        send_cmd(2'b10, 2'd0, 8'h00);
        wait_idle(bc);
        chk("dump_busy_cycles", 32'(bc), 32'd4);
        tick();
        check_four("dump", 1'b1, 8'hFE, 8'hFF, 8'h00, 8'h01);
        chk("dump_no_writes", 32'(wr_log.size()), 32'd0);
        chk("dump_done_cnt", 32'(done_cnt), 32'd1);

        // Dump with a 3-cycle stall on beat 1
        clear_logs();
        send_cmd(2'b10, 2'd0, 8'h00);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_addr", 32'(out_addr), 32'd1);
            chk("stall_data", 32'(out_data), 32'hFF);
            tick();
        end
        out_ready = 1'b1;
        wait_idle(bc);
        tick();
        check_four("stall_dump", 1'b1, 8'hFE, 8'hFF, 8'h00, 8'h01);
        chk("stall_done_cnt", 32'(done_cnt), 32'd1);

        // Commands offered while busy are ignored; reserved op is a no-op
        clear_logs();
        send_cmd(2'b01, 2'd0, 8'h30);
        cmd_op = 2'b00; cmd_addr = 2'd3; cmd_data = 8'h77; cmd_valid = 1'b1;
        tick(); tick(); tick();
        cmd_valid = 1'b0;
        wait_idle(bc);
        tick();
        check_four("busy_fill", 1'b0, 8'h30, 8'h31, 8'h32, 8'h33);
        chk("busy_done_cnt", 32'(done_cnt), 32'd1);
        clear_logs();
        send_cmd(2'b11, 2'd1, 8'h55);
        tick(); tick();
        chk("rsv_writes", 32'(wr_log.size()), 32'd0);
        chk("rsv_done_cnt", 32'(done_cnt), 32'd0);
        chk("rsv_ready", 32'(cmd_ready), 32'd1);

        // Reset in the middle of a fill
        for (int i = 0; i < 4; i++) begin
            send_cmd(2'b00, 2'(i), 8'h00);
            wait_idle(bc);
        end
        clear_logs();
        send_cmd(2'b01, 2'd0, 8'h10);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("postrst_ready", 32'(cmd_ready), 32'd1);
        chk("postrst_writes", 32'(wr_log.size()), 32'd2);
        clear_logs();
        send_cmd(2'b10, 2'd0, 8'h00);
        wait_idle(bc);
        tick();
        check_four("partial_dump", 1'b1, 8'h10, 8'h11, 8'h00, 8'h00);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
